// File: rtl/msg_send_driver.sv
// Transmit framer for the 128-bit message FIFO link: writes a header word, then
// payload words, and puts a running modulo-256 byte checksum into the final word.
module msg_send_driver #(
    parameter logic [31:0] HEADER_MAGIC   = 32'hFDF7_EB90,
    parameter logic [15:0] FRAME_CNT_INIT = 16'h0000
) (
    input  logic         sys_clk_i,
    input  logic         rst_i,
    input  logic         send_req_i,
    input  logic [15:0]  send_frame_len_i,
    input  logic [3:0]   send_frame_type_i,
    input  logic [7:0]   send_src_id_i,
    input  logic [7:0]   send_des_id_i,
    input  logic [7:0]   send_data_type_i,
    input  logic [7:0]   send_data_channel_i,
    input  logic [15:0]  send_data_field_len_i,
    output logic         send_busy_o,
    output logic         send_done_o,
    input  logic         msg_send_valid_i,
    output logic         msg_send_ready_o,
    input  logic [127:0] msg_send_data_i,
    output logic         wr_clk_o,
    output logic         wr_en_o,
    output logic [127:0] wr_dout_o,
    input  logic         wr_full_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2
    } state_t;

    // Modulo-256 sum of the word's bytes; the low byte is optional because the
    // final word's low byte is replaced by the checksum itself.
    function automatic logic [7:0] byte_sum(input logic [127:0] word, input logic incl_low);
        logic [7:0] acc;
        acc = incl_low ? word[7:0] : 8'h00;
        for (int i = 1; i < 16; i++) begin
            acc = acc + word[i*8 +: 8];
        end
        return acc;
    endfunction

    state_t         state_q, state_d;
    logic [15:0]    frame_len_q, frame_len_d;
    logic [3:0]     frame_type_q, frame_type_d;
    logic [7:0]     src_id_q, src_id_d;
    logic [7:0]     des_id_q, des_id_d;
    logic [7:0]     data_type_q, data_type_d;
    logic [7:0]     data_channel_q, data_channel_d;
    logic [15:0]    data_field_len_q, data_field_len_d;
    logic [18:0]    word_cnt_q, word_cnt_d;
    logic [7:0]     checksum_q, checksum_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           wr_en_q, wr_en_d;
    logic [127:0]   wr_dout_q, wr_dout_d;
    logic           send_done_q, send_done_d;
    logic           send_busy_q, send_busy_d;

    logic           ready_s;
    logic           xfer_s;
    logic           is_last_s;
    logic [18:0]    n_words_s;
    logic [127:0]   header_s;

    assign ready_s   = (state_q == S_DATA) && !wr_full_i;
    assign xfer_s    = ready_s && msg_send_valid_i;
    // N = (frame_len+1)*4 reaches 2^18, hence the 19-bit arithmetic.
    assign n_words_s = ({3'b000, frame_len_q} + 19'd1) << 2;
    assign is_last_s = ((word_cnt_q + 19'd1) == n_words_s);
    assign header_s  = {HEADER_MAGIC, frame_len_q, 12'h000, frame_type_q, frame_cnt_q,
                        src_id_q, des_id_q, data_type_q, data_channel_q, data_field_len_q};

    // State register.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (send_req_i) state_d = S_HEADER;
                else            state_d = S_IDLE;
            end
            S_HEADER: begin
                if (!wr_full_i) state_d = S_DATA;
                else            state_d = S_HEADER;
            end
            S_DATA: begin
                if (xfer_s && is_last_s) state_d = S_IDLE;
                else                     state_d = S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        frame_len_d      = frame_len_q;
        frame_type_d     = frame_type_q;
        src_id_d         = src_id_q;
        des_id_d         = des_id_q;
        data_type_d      = data_type_q;
        data_channel_d   = data_channel_q;
        data_field_len_d = data_field_len_q;
        word_cnt_d       = word_cnt_q;
        checksum_d       = checksum_q;
        frame_cnt_d      = frame_cnt_q;
        wr_en_d          = 1'b0;
        wr_dout_d        = wr_dout_q;
        send_done_d      = 1'b0;
        send_busy_d      = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (send_req_i) begin
                    frame_len_d      = send_frame_len_i;
                    frame_type_d     = send_frame_type_i;
                    src_id_d         = send_src_id_i;
                    des_id_d         = send_des_id_i;
                    data_type_d      = send_data_type_i;
                    data_channel_d   = send_data_channel_i;
                    data_field_len_d = send_data_field_len_i;
                    word_cnt_d       = 19'd0;
                    checksum_d       = 8'h00;
                end else begin
                    word_cnt_d = word_cnt_q;
                end
            end
            S_HEADER: begin
                if (!wr_full_i) begin
                    wr_en_d    = 1'b1;
                    wr_dout_d  = header_s;
                    word_cnt_d = 19'd1;
                end else begin
                    wr_en_d = 1'b0;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    wr_en_d    = 1'b1;
                    word_cnt_d = word_cnt_q + 19'd1;
                    if (is_last_s) begin
                        wr_dout_d   = {msg_send_data_i[127:8],
                                       checksum_q + byte_sum(msg_send_data_i, 1'b0)};
                        send_done_d = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        wr_dout_d  = msg_send_data_i;
                        checksum_d = checksum_q + byte_sum(msg_send_data_i, 1'b1);
                    end
                end else begin
                    wr_en_d = 1'b0;
                end
            end
            default: begin
                wr_en_d = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            frame_len_q      <= 16'h0000;
            frame_type_q     <= 4'h0;
            src_id_q         <= 8'h00;
            des_id_q         <= 8'h00;
            data_type_q      <= 8'h00;
            data_channel_q   <= 8'h00;
            data_field_len_q <= 16'h0000;
            word_cnt_q       <= 19'd0;
            checksum_q       <= 8'h00;
            frame_cnt_q      <= FRAME_CNT_INIT;
            wr_en_q          <= 1'b0;
            wr_dout_q        <= 128'd0;
            send_done_q      <= 1'b0;
            send_busy_q      <= 1'b0;
        end else begin
            frame_len_q      <= frame_len_d;
            frame_type_q     <= frame_type_d;
            src_id_q         <= src_id_d;
            des_id_q         <= des_id_d;
            data_type_q      <= data_type_d;
            data_channel_q   <= data_channel_d;
            data_field_len_q <= data_field_len_d;
            word_cnt_q       <= word_cnt_d;
            checksum_q       <= checksum_d;
            frame_cnt_q      <= frame_cnt_d;
            wr_en_q          <= wr_en_d;
            wr_dout_q        <= wr_dout_d;
            send_done_q      <= send_done_d;
            send_busy_q      <= send_busy_d;
        end
    end

    assign wr_clk_o         = sys_clk_i;
    assign wr_en_o          = wr_en_q;
    assign wr_dout_o        = wr_dout_q;
    assign send_done_o      = send_done_q;
    assign send_busy_o      = send_busy_q;
    assign msg_send_ready_o = ready_s;

endmodule

// File: tb/tb_msg_send_driver.sv
// Randomised bench for msg_send_driver: two instances (counter init 0000 and FFFF)
// share stimulus; every FIFO write is checked against a frame-level reference model.
module tb_msg_send_driver;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [15:0]  f_len;
    logic [3:0]   f_type;
    logic [7:0]   f_src, f_des, f_dtype, f_ch;
    logic [15:0]  f_dflen;
    logic         valid;
    logic [127:0] data;
    logic         full;

    logic         busy_a, done_a, ready_a, wrclk_a, wr_en_a;
    logic [127:0] dout_a;
    logic         busy_b, done_b, ready_b, wrclk_b, wr_en_b;
    logic [127:0] dout_b;

    always #5 clk = ~clk;

    msg_send_driver u_dut_a (
        .sys_clk_i(clk), .rst_i(rst), .send_req_i(req),
        .send_frame_len_i(f_len), .send_frame_type_i(f_type),
        .send_src_id_i(f_src), .send_des_id_i(f_des),
        .send_data_type_i(f_dtype), .send_data_channel_i(f_ch),
        .send_data_field_len_i(f_dflen),
        .send_busy_o(busy_a), .send_done_o(done_a),
        .msg_send_valid_i(valid), .msg_send_ready_o(ready_a), .msg_send_data_i(data),
        .wr_clk_o(wrclk_a), .wr_en_o(wr_en_a), .wr_dout_o(dout_a), .wr_full_i(full)
    );

    msg_send_driver #(.FRAME_CNT_INIT(16'hFFFF)) u_dut_b (
        .sys_clk_i(clk), .rst_i(rst), .send_req_i(req),
        .send_frame_len_i(f_len), .send_frame_type_i(f_type),
        .send_src_id_i(f_src), .send_des_id_i(f_des),
        .send_data_type_i(f_dtype), .send_data_channel_i(f_ch),
        .send_data_field_len_i(f_dflen),
        .send_busy_o(busy_b), .send_done_o(done_b),
        .msg_send_valid_i(valid), .msg_send_ready_o(ready_b), .msg_send_data_i(data),
        .wr_clk_o(wrclk_b), .wr_en_o(wr_en_b), .wr_dout_o(dout_b), .wr_full_i(full)
    );

    typedef struct {
        logic [127:0] word;
        logic         last;
    } exp_t;

    exp_t         exp_a[$];
    exp_t         exp_b[$];
    logic [127:0] capt_a[$];
    logic [127:0] capt_b[$];
    int           checks = 0;
    int           errors = 0;
    int           frames_done = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write of each instance must be the next expected word.
    always @(negedge clk) begin
        exp_t e;
        if (wr_en_a === 1'b1) begin
            capt_a.push_back(dout_a);
            if (exp_a.size() == 0) begin
                check_val("a_extra_write", wr_en_a, 1'b0);
            end else begin
                e = exp_a.pop_front();
                check_val("a_word", dout_a, e.word);
                check_val("a_done", done_a, e.last);
                if (e.last) check_val("a_busy_at_done", busy_a, 1'b0);
            end
        end else if (done_a === 1'b1) begin
            check_val("a_done_without_write", done_a, 1'b0);
        end
        if (wr_en_b === 1'b1) begin
            capt_b.push_back(dout_b);
            if (exp_b.size() == 0) begin
                check_val("b_extra_write", wr_en_b, 1'b0);
            end else begin
                e = exp_b.pop_front();
                check_val("b_word", dout_b, e.word);
                check_val("b_done", done_b, e.last);
            end
        end
    end

    // Reference frame: header fields from the request, checksum over payload bytes.
    task automatic model_frame(input logic [127:0] pay[$], input logic [15:0] cnt_a);
        exp_t e;
        int   sum;
        int   n;
        logic [15:0] cnt_b;
        cnt_b = cnt_a + 16'hFFFF;
        n = pay.size();
        e.last = 1'b0;
        e.word = {32'hFDF7_EB90, f_len, 12'h000, f_type, cnt_a, f_src, f_des, f_dtype, f_ch, f_dflen};
        exp_a.push_back(e);
        e.word[63:48] = cnt_b;
        exp_b.push_back(e);
        sum = 0;
        for (int i = 0; i < n; i++) begin
            for (int b = (i == n - 1) ? 1 : 0; b < 16; b++) sum += int'(pay[i][b*8 +: 8]);
            e.word = pay[i];
            e.last = (i == n - 1);
            if (e.last) e.word[7:0] = sum[7:0];
            exp_a.push_back(e);
            exp_b.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; valid = 1'b0; full = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rst_wr_en", wr_en_a, 1'b0);
        check_val("rst_busy", busy_a, 1'b0);
        check_val("rst_done", done_a, 1'b0);
        check_val("rst_ready", ready_a, 1'b0);
        check_val("rst_dout", dout_a, 128'd0);
        check_val("rst_busy_b", busy_b, 1'b0);
        exp_a.delete(); exp_b.delete();
        frames_done = 0;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // mode 0: random valid/full; 1: all-ones-byte payload, valid steady; 2: 5-cycle full hold.
    task automatic run_frame(input logic [15:0] len, input logic [3:0] typ, input logic [7:0] src,
                             input logic [7:0] des, input logic [7:0] dt, input logic [7:0] ch,
                             input logic [15:0] dfl, input int mode, input bit mid_req, input int abort_at);
        logic [127:0] pay[$];
        int n_data, idx, cyc, held;
        bit took, hold_now;
        n_data = (int'(len) + 1) * 4 - 1;
        for (int i = 0; i < n_data; i++)
            pay.push_back(mode == 1 ? {16{8'h01}} : {$urandom, $urandom, $urandom, $urandom});
        capt_a.delete(); capt_b.delete();
        f_len = len; f_type = typ; f_src = src; f_des = des; f_dtype = dt; f_ch = ch; f_dflen = dfl;
        model_frame(pay, 16'(frames_done));
        frames_done++;
        req = 1'b1; full = 1'b0; valid = 1'b0;
        @(posedge clk); #1;
        req = 1'b0;
        idx = 0; cyc = 0; held = 0;
        while (idx < n_data && cyc < 2000) begin
            hold_now = (mode == 2 && idx == 2 && held < 5);
            if (hold_now) begin
                full = 1'b1; held++;
            end else begin
                full = (mode == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            valid = (mode == 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
            data  = valid ? pay[idx] : {$urandom, $urandom, $urandom, $urandom};
            if (mid_req && cyc == 3) begin
                req = 1'b1;
                {f_len, f_type, f_src} = 28'($urandom);
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            if (cyc == 0) check_val("busy_after_req", busy_a, 1'b1);
            if (hold_now) check_val("ready_while_full", ready_a, 1'b0);
            if (hold_now && held >= 2) check_val("no_write_while_full", wr_en_a, 1'b0);
            took = valid && ready_a;
            @(posedge clk); #1;
            if (took) idx++;
            cyc++;
            if (abort_at >= 0 && idx == abort_at) begin
                do_reset();
                return;
            end
        end
        check_val("frame_timeout", (cyc < 2000), 1'b1);
        valid = 1'b0; req = 1'b0; full = 1'b0;
        for (int i = 0; i < 20 && exp_a.size() > 0; i++) @(posedge clk);
        #1;
        @(negedge clk);
        check_val("drain_a", exp_a.size(), 0);
        check_val("drain_b", exp_b.size(), 0);
        check_val("write_count", capt_a.size(), n_data + 1);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; valid = 1'b0; full = 1'b0; data = 128'd0;
        f_len = 16'h0; f_type = 4'h0; f_src = 8'h0; f_des = 8'h0; f_dtype = 8'h0; f_ch = 8'h0; f_dflen = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        run_frame(16'h0000, 4'h3, 8'h01, 8'h02, 8'h10, 8'h05, 16'h0030, 1, 1'b0, -1);
        check_val("hdr_size", capt_a.size(), 4);
        if (capt_a.size() == 4 && capt_b.size() == 4) begin
            check_val("hdr_literal", capt_a[0], 128'hFDF7EB90_0000_0003_0000_0102_1005_0030);
            check_val("csum_literal", capt_a[3][7:0], 8'h2F);
            check_val("b_cnt_init", capt_b[0][63:48], 16'hFFFF);
        end

        run_frame(16'h0000, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), 0, 1'b0, -1);
        if (capt_a.size() > 0 && capt_b.size() > 0) begin
            check_val("a_cnt_second", capt_a[0][63:48], 16'h0001);
            check_val("b_cnt_wrap", capt_b[0][63:48], 16'h0000);
        end

        run_frame(16'h0000, 4'h1, 8'h11, 8'h22, 8'h33, 8'h44, 16'h0055, 2, 1'b0, -1);
        run_frame(16'h0000, 4'h2, 8'h12, 8'h34, 8'h56, 8'h78, 16'h0100, 1, 1'b1, -1);
        run_frame(16'h0000, 4'h7, 8'h21, 8'h43, 8'h65, 8'h87, 16'h0200, 0, 1'b0, -1);
        if (capt_a.size() > 0) check_val("a_cnt_after_ignored_req", capt_a[0][63:48], 16'h0004);

        run_frame(16'h0000, 4'h5, 8'hA0, 8'hB0, 8'hC0, 8'hD0, 16'h0010, 1, 1'b0, 2);
        run_frame(16'h0000, 4'h6, 8'hA1, 8'hB1, 8'hC1, 8'hD1, 16'h0011, 0, 1'b0, -1);
        if (capt_a.size() > 0 && capt_b.size() > 0) begin
            check_val("a_cnt_after_reset", capt_a[0][63:48], 16'h0000);
            check_val("b_cnt_after_reset", capt_b[0][63:48], 16'hFFFF);
        end

        run_frame(16'h0001, 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), 0, 1'b0, -1);
        check_val("len1_writes", capt_a.size(), 8);

        for (int k = 0; k < 12; k++) begin
            run_frame(16'($urandom_range(0, 3)), 4'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom), 16'($urandom), 0, 1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
